// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types for the I2C slave receive path
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_DRIVE,
        NACK_HOLD
    } rx_state_t;

endpackage

// File: rtl/i2c_rx_byte_ctrl_if.sv
// rtl/i2c_rx_byte_ctrl_if.sv - edge/strobe inputs and byte outputs of the receive controller
interface i2c_rx_byte_ctrl_if #(
    parameter int DATA_BITS = 8
);

    logic                 rising_edge_found;
    logic                 falling_edge_found;
    logic                 sda_in;
    logic                 start_found;
    logic                 stop_found;
    logic                 ack_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 byte_received;
    logic                 sda_oe;
    logic                 bus_busy;

    modport master (
        output rising_edge_found, falling_edge_found, sda_in, start_found, stop_found, ack_en,
        input  rx_data, byte_received, sda_oe, bus_busy
    );

    modport slave (
        input  rising_edge_found, falling_edge_found, sda_in, start_found, stop_found, ack_en,
        output rx_data, byte_received, sda_oe, bus_busy
    );

endinterface

// File: rtl/i2c_rx_sr.sv
// rtl/i2c_rx_sr.sv - MSB-first SDA shift register with synchronous clear
module i2c_rx_sr #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 clear,
    input  logic                 din,
    output logic [DATA_BITS-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[DATA_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/i2c_rx_byte_ctrl.sv
// rtl/i2c_rx_byte_ctrl.sv - frames SCL-sampled SDA bits into bytes and drives the ACK clock
module i2c_rx_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_rx_byte_ctrl_if.slave    bus
);

    localparam int            CW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

    rx_state_t            state, state_n;
    logic [CW-1:0]        count, count_n;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
    logic                 br_q, br_n;
    logic                 sda_oe_q, sda_oe_n;
    logic                 busy_q, busy_n;
    logic                 shift_en, sr_clear;
    logic [DATA_BITS-1:0] sr_q;
    logic                 sr_msb_unused;
    logic                 fall_only;

    i2c_rx_sr #(.DATA_BITS(DATA_BITS)) u_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (sr_clear),
        .din      (bus.sda_in),
        .q        (sr_q)
    );

    // The completed word is assembled from the register plus the bit arriving this cycle,
    // so the register's own MSB is never needed.
    assign sr_msb_unused = sr_q[DATA_BITS-1];
    assign fall_only     = bus.falling_edge_found && !bus.rising_edge_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rx_data_q <= '0;
            br_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            rx_data_q <= rx_data_n;
            br_q      <= br_n;
            sda_oe_q  <= sda_oe_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        rx_data_n = rx_data_q;
        br_n      = 1'b0;
        sda_oe_n  = sda_oe_q;
        busy_n    = busy_q;
        shift_en  = 1'b0;
        sr_clear  = 1'b0;
        if (bus.stop_found) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            count_n  = '0;
        end else if (bus.start_found) begin
            state_n  = SHIFT;
            sda_oe_n = 1'b0;
            busy_n   = 1'b1;
            count_n  = '0;
            sr_clear = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.rising_edge_found) begin
                        shift_en = 1'b1;
                        count_n  = (count == FULL) ? count : count + 1'b1;
                        if (count == LAST) begin
                            rx_data_n = {sr_q[DATA_BITS-2:0], bus.sda_in};
                            br_n      = 1'b1;
                            state_n   = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (fall_only) begin
                        state_n  = bus.ack_en ? ACK_DRIVE : NACK_HOLD;
                        sda_oe_n = bus.ack_en;
                    end
                end
                ACK_DRIVE: begin
                    if (fall_only) begin
                        sda_oe_n = 1'b0;
                        count_n  = '0;
                        state_n  = SHIFT;
                    end
                end
                NACK_HOLD: begin
                    if (fall_only) begin
                        count_n = '0;
                        state_n = SHIFT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.byte_received = br_q;
    assign bus.sda_oe        = sda_oe_q;
    assign bus.bus_busy      = busy_q;

endmodule

// File: tb/tb_i2c_rx_byte_ctrl.sv
// tb/tb_i2c_rx_byte_ctrl.sv - directed and randomized I2C byte traffic against a transaction-level model
module tb_i2c_rx_byte_ctrl;

    logic clk = 1'b0;
    logic rst;

    i2c_rx_byte_ctrl_if #(.DATA_BITS(8)) bus ();

    i2c_rx_byte_ctrl #(.DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         exp_pulses = 0;
    int         seen_pulses = 0;
    logic       consec = 1'b0;
    logic       prev_br = 1'b0;
    logic [7:0] exp_rx = 8'h00;

    always @(negedge clk) begin
        if (bus.byte_received === 1'b1) begin
            seen_pulses++;
            if (prev_br === 1'b1) consec = 1'b1;
        end
        prev_br = bus.byte_received;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic s, input logic st, input logic sp);
        bus.rising_edge_found  = r;
        bus.falling_edge_found = f;
        bus.sda_in             = s;
        bus.start_found        = st;
        bus.stop_found         = sp;
        @(negedge clk);
        bus.rising_edge_found  = 1'b0;
        bus.falling_edge_found = 1'b0;
        bus.start_found        = 1'b0;
        bus.stop_found         = 1'b0;
    endtask

    task automatic do_start();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("start_busy", 16'(bus.bus_busy), 16'd1);
        chk("start_oe", 16'(bus.sda_oe), 16'd0);
        chk("start_no_pulse", 16'(bus.byte_received), 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_stop();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stop_busy", 16'(bus.bus_busy), 16'd0);
        chk("stop_oe", 16'(bus.sda_oe), 16'd0);
        chk("stop_rx_kept", 16'(bus.rx_data), 16'(exp_rx));
    endtask

    task automatic partial_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, b, 1'b0, 1'b0);
            chk("partial_no_pulse", 16'(bus.byte_received), 16'd0);
            cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
        end
    endtask

    // full=0 stops right after the ACK decision, leaving the controller inside the ACK clock
    task automatic send_byte(input logic [7:0] val, input logic ack, input bit full);
        logic b;
        bus.ack_en = ack;
        for (int i = 0; i < 8; i++) begin
            b = val[7-i];
            cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
            cyc(1'b1, 1'($urandom_range(0, 1)), b, 1'b0, 1'b0);
            if (i == 7) begin
                exp_rx = val;
                exp_pulses++;
                chk("byte_received", 16'(bus.byte_received), 16'd1);
                chk("rx_data", 16'(bus.rx_data), 16'(exp_rx));
            end else begin
                chk("early_pulse", 16'(bus.byte_received), 16'd0);
            end
            cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
            chk("pulse_width", 16'(bus.byte_received), 16'd0);
            if (i < 7) cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ack_oe_set", 16'(bus.sda_oe), 16'(ack));
        bus.ack_en = ~ack;
        if (!full) return;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ack_oe_hold", 16'(bus.sda_oe), 16'(ack));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_oe_hold2", 16'(bus.sda_oe), 16'(ack));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ack_oe_release", 16'(bus.sda_oe), 16'd0);
        chk("rx_held", 16'(bus.rx_data), 16'(exp_rx));
    endtask

    initial begin
        int nb;
        rst = 1'b1;
        bus.rising_edge_found  = 1'b0;
        bus.falling_edge_found = 1'b0;
        bus.sda_in             = 1'b1;
        bus.start_found        = 1'b0;
        bus.stop_found         = 1'b0;
        bus.ack_en             = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx", 16'(bus.rx_data), 16'd0);
        chk("rst_br", 16'(bus.byte_received), 16'd0);
        chk("rst_oe", 16'(bus.sda_oe), 16'd0);
        chk("rst_busy", 16'(bus.bus_busy), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        do_start();
        send_byte(8'hA5, 1'b1, 1'b1);
        do_stop();

        do_start();
        send_byte(8'h3C, 1'b0, 1'b1);
        do_stop();

        do_start();
        send_byte(8'h12, 1'b1, 1'b1);
        send_byte(8'hFE, 1'b1, 1'b1);
        do_stop();

        do_start();
        partial_bits(4);
        do_start();
        chk("restart_rx_kept", 16'(bus.rx_data), 16'(exp_rx));
        send_byte(8'h5A, 1'b1, 1'b1);
        do_stop();

        do_start();
        send_byte(8'($urandom), 1'b1, 1'b0);
        do_stop();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            chk("idle_no_pulse", 16'(bus.byte_received), 16'd0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("idle_rx_kept", 16'(bus.rx_data), 16'(exp_rx));

        do_start();
        send_byte(8'($urandom), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_rx = 8'h00;
        chk("midrst_rx", 16'(bus.rx_data), 16'd0);
        chk("midrst_br", 16'(bus.byte_received), 16'd0);
        chk("midrst_oe", 16'(bus.sda_oe), 16'd0);
        chk("midrst_busy", 16'(bus.bus_busy), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("nostart_rx", 16'(bus.rx_data), 16'd0);
        chk("nostart_oe", 16'(bus.sda_oe), 16'd0);
        chk("nostart_busy", 16'(bus.bus_busy), 16'd0);

        for (int s = 0; s < 4; s++) begin
            do_start();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                send_byte(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            end
            if ($urandom_range(0, 1) == 1) begin
                partial_bits($urandom_range(1, 7));
                do_start();
                send_byte(8'($urandom), 1'b1, 1'b1);
            end
            do_stop();
        end

        chk("pulse_count", 16'(seen_pulses), 16'(exp_pulses));
        chk("no_back_to_back", 16'(consec), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
